// File: rtl/bin_to_dec_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) driving active-low 7-segment digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digit positions above the most significant non-zero digit.
module bin_to_dec_display #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  onSwitch,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            digs [0:DIGITS-1]
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  // min(10^DIGITS, 2^WIDTH); saturating keeps the arithmetic within WIDTH+5 bits
  function automatic logic [WIDTH:0] dec_limit();
    logic [WIDTH+4:0] acc;
    logic [WIDTH+4:0] cap;
    cap = (WIDTH+5)'(1) << WIDTH;
    acc = (WIDTH+5)'(1);
    for (int i = 0; i < DIGITS; i++) begin
      acc = acc * (WIDTH+5)'(10);
      if (acc > cap) begin
        acc = cap;
      end else begin
        acc = acc;
      end
    end
    return acc[WIDTH:0];
  endfunction

  localparam logic [WIDTH:0] DEC_LIMIT    = dec_limit();
  localparam bit             OVF_POSSIBLE = (DEC_LIMIT[WIDTH] == 1'b0);

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              done_q, done_d;
  logic              ovf_value_s;
  logic [BW-1:0]     adj_s;

  assign ovf_value_s = OVF_POSSIBLE ? ({1'b0, value} >= DEC_LIMIT) : 1'b0;
  assign adj_s       = add3(scratch_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; top-digit carries fall off the scratch so bcd keeps the low DIGITS digits
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d    = value;
          scratch_d  = '0;
          cnt_d      = CW'(WIDTH - 1);
          ovf_pend_d = ovf_value_s;
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = {adj_s[BW-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = UPDATE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      UPDATE: begin
        bcd_d   = scratch_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Segment decode; blanking and overflow dash take priority over digit values
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    nz = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      digs[i] = 8'hFF;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!onSwitch) begin
        digs[i] = 8'hFF;
      end else if (ovf_q) begin
        digs[i] = 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
      end else if ((i != 0) && !nz && (bcd_q[4*i +: 4] == 4'd0)) begin
        digs[i] = 8'hFF;
`endif
      end else begin
        digs[i] = seg7(bcd_q[4*i +: 4]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      nz = nz | (bcd_q[4*i +: 4] != 4'd0);
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;

endmodule

// File: tb/tb_bin_to_dec_display.sv
// Scoreboard bench for bin_to_dec_display (WIDTH=20, DIGITS=6); expected digit patterns follow LEADING_ZERO_BLANK_EN.
module tb_bin_to_dec_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] value;
  logic        load;
  logic        onSwitch;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] bcd;
  logic [7:0]  digs [0:5];

  bin_to_dec_display #(.WIDTH(20), .DIGITS(6)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .onSwitch (onSwitch),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd      (bcd),
    .digs     (digs)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] D_123456 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
  localparam logic [47:0] D_999999 = {6{8'h90}};
  localparam logic [47:0] D_OVF    = {6{8'hBF}};
  localparam logic [47:0] D_OFF    = {6{8'hFF}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [47:0] D_7   = {{5{8'hFF}}, 8'hF8};
  localparam logic [47:0] D_0   = {{5{8'hFF}}, 8'hC0};
  localparam logic [47:0] D_500 = {8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0, 8'hC0};
  localparam logic [47:0] D_42  = {{4{8'hFF}}, 8'h99, 8'hA4};
`else
  localparam logic [47:0] D_7   = {{5{8'hC0}}, 8'hF8};
  localparam logic [47:0] D_0   = {6{8'hC0}};
  localparam logic [47:0] D_500 = {8'hC0, 8'hC0, 8'hC0, 8'h92, 8'hC0, 8'hC0};
  localparam logic [47:0] D_42  = {{4{8'hC0}}, 8'h99, 8'hA4};
`endif

  typedef struct packed {
    logic [23:0] bcd;
    logic        ovf;
    logic [47:0] digs;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   done_cnt  = 0;

  function automatic logic [47:0] pack_digs();
    logic [47:0] p;
    for (int i = 0; i < 6; i++) p[8*i +: 8] = digs[i];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [19:0] v, input logic [23:0] eb, input logic eo, input logic [47:0] ed);
    sb_q.push_back('{bcd: eb, ovf: eo, digs: ed});
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      chk("sb_expected_present", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_bcd", 64'(bcd), 64'(e.bcd));
        chk("sb_ovf", 64'(overflow), 64'(e.ovf));
        chk("sb_digs", 64'(pack_digs()), 64'(e.digs));
      end
    end
  end

  initial begin
    int n;
    int dc;
    reset_n  = 1'b0;
    value    = '0;
    load     = 1'b0;
    onSwitch = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_digs", 64'(pack_digs()), 64'(D_0));

    // Basic conversion with latency check
    issue(20'd123456, 24'h123456, 1'b0, D_123456);
    chk("busy_after_load", 64'(busy), 64'd1);
    wait_done(n);
    chk("latency_123456", 64'(n), 64'd21);
    chk("busy_in_done", 64'(busy), 64'd0);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);

    // Back-to-back: load in the done cycle
    issue(20'd999999, 24'h999999, 1'b0, D_999999);
    wait_done(n);
    chk("latency_999999", 64'(n), 64'd21);
    issue(20'd7, 24'h000007, 1'b0, D_7);
    chk("b2b_accepted_busy", 64'(busy), 64'd1);
    chk("b2b_done_dropped", 64'(done), 64'd0);
    wait_done(n);
    chk("latency_7", 64'(n), 64'd21);

    // Overflow and recovery
    issue(20'd1048575, 24'h048575, 1'b1, D_OVF);
    wait_done(n);
    chk("latency_ovf", 64'(n), 64'd21);
    tick();
    chk("ovf_held", 64'(overflow), 64'd1);
    issue(20'd0, 24'h000000, 1'b0, D_0);
    wait_done(n);
    tick();
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Loads during conversion are ignored
    dc = done_cnt;
    issue(20'd500, 24'h000500, 1'b0, D_500);
    repeat (4) tick();
    value = 20'd9;
    load  = 1'b1;
    repeat (6) tick();
    load  = 1'b0;
    wait_done(n);
    chk("latency_500", 64'(n + 10), 64'd21);
    repeat (30) tick();
    chk("single_done_500", 64'(done_cnt - dc), 64'd1);
    chk("bcd_500_held", 64'(bcd), 64'h000500);

    // Reset mid-conversion aborts without done
    value = 20'd123;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dc = done_cnt;
    reset_n = 1'b1;
    repeat (30) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(dc));

    // Display enable toggling on a held result
    issue(20'd42, 24'h000042, 1'b0, D_42);
    wait_done(n);
    tick();
    dc = done_cnt;
    onSwitch = 1'b0;
    #1;
    chk("off_digs", 64'(pack_digs()), 64'(D_OFF));
    tick();
    tick();
    chk("off_digs_held", 64'(pack_digs()), 64'(D_OFF));
    onSwitch = 1'b1;
    #1;
    chk("on_digs_42", 64'(pack_digs()), 64'(D_42));
    tick();
    chk("on_no_new_done", 64'(done_cnt), 64'(dc));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
